// File: rtl/reset_pkg.sv
// reset_pkg: shared state type and width helper for the reset sequencer.
package reset_pkg;
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} rst_seq_state_t;
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/reset_sync.sv
// reset_sync: asynchronous-assert, synchronous-release reset synchronizer.
module reset_sync #(
  parameter bit INPUT_POLARITY = 1'b1,
  parameter bit OUTPUT_POLARITY = 1'b1,
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic arst,
  output logic srst
);
  logic act;
  logic [STAGES-1:0] sync;
  assign act = arst == INPUT_POLARITY;
  always_ff @(posedge clk or posedge act)
    if (act) sync <= '1;
    else sync <= {sync[STAGES-2:0], 1'b0};
  assign srst = OUTPUT_POLARITY ? sync[STAGES-1] : ~sync[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered, synchronously released staged resets from an async
// reset input and a level-sensitive software reset request.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int MIN_ASSERT = 8,
  parameter int STAGE_DELAY = 16,
  parameter bit OUTPUT_POLARITY = 1'b1
) (
  input  logic                  clk,
  input  logic                  async_reset_i,
  input  logic                  sw_reset_req_i,
  output logic                  sw_reset_ack_o,
  output logic [NUM_STAGES-1:0] reset_o,
  output logic                  ready_o
);
  localparam int CW = cnt_width(MIN_ASSERT, STAGE_DELAY);
  localparam int IW = $clog2(NUM_STAGES + 1);
  if (NUM_STAGES < 1 || MIN_ASSERT < 1 || STAGE_DELAY < 1) begin : g_bad_params
    $error("reset_sequencer: NUM_STAGES, MIN_ASSERT and STAGE_DELAY must be >= 1");
  end
  logic rst_int;
  rst_seq_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [NUM_STAGES-1:0] asrt, asrt_n;
  logic req_q, ack;
  reset_sync #(.INPUT_POLARITY(1'b1), .OUTPUT_POLARITY(1'b1), .STAGES(2)) u_sync (
    .clk(clk),
    .arst(async_reset_i),
    .srst(rst_int)
  );
  always_ff @(posedge clk or posedge rst_int)
    if (rst_int) begin
      state <= HOLD;
      cnt <= '0;
      idx <= '0;
      asrt <= '1;
      req_q <= 1'b0;
      ack <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      asrt <= asrt_n;
      req_q <= sw_reset_req_i;
      ack <= sw_reset_req_i & ~req_q;
    end
  // A request wins over any release due on the same edge; the first low sample
  // after a request does not count toward the hold time.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    asrt_n = asrt;
    if (sw_reset_req_i) begin
      state_n = HOLD;
      cnt_n = '0;
      idx_n = '0;
      asrt_n = '1;
    end else if (state == HOLD && !req_q) begin
      if (cnt == CW'(MIN_ASSERT - 1)) begin
        cnt_n = '0;
        asrt_n = asrt & ~(NUM_STAGES'(1) << idx);
        idx_n = idx + 1'b1;
        state_n = NUM_STAGES == 1 ? RUN : RELEASE;
      end else cnt_n = cnt + 1'b1;
    end else if (state == RELEASE) begin
      if (cnt == CW'(STAGE_DELAY - 1)) begin
        cnt_n = '0;
        asrt_n = asrt & ~(NUM_STAGES'(1) << idx);
        idx_n = idx + 1'b1;
        state_n = idx == IW'(NUM_STAGES - 1) ? RUN : RELEASE;
      end else cnt_n = cnt + 1'b1;
    end
  end
  assign reset_o = OUTPUT_POLARITY ? asrt : ~asrt;
  assign ready_o = state == RUN;
  assign sw_reset_ack_o = ack;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized stimulus against a timing model of the staged release.
module tb_reset_sequencer;
  localparam int NS = 3, MA = 8, SD = 16;
  localparam bit POL = 1'b1;
  logic clk = 1'b0, arst = 1'b1, req = 1'b0, req1 = 1'b0;
  logic ack, ready, ack1, ready1;
  logic [NS-1:0] rst_o;
  logic [0:0] rst1;
  int compared = 0, mismatched = 0;
  int t = 0, since = 0;
  bit prev = 1'b0, m_ack = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk(clk), .async_reset_i(arst), .sw_reset_req_i(req),
    .sw_reset_ack_o(ack), .reset_o(rst_o), .ready_o(ready)
  );
  reset_sequencer #(.NUM_STAGES(1), .MIN_ASSERT(1), .STAGE_DELAY(16), .OUTPUT_POLARITY(1'b0)) dut1 (
    .clk(clk), .async_reset_i(arst), .sw_reset_req_i(req1),
    .sw_reset_ack_o(ack1), .reset_o(rst1), .ready_o(ready1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // t = clock edges counted toward release since the last reset source cleared
  function automatic logic [NS-1:0] exp_rst(input int tt);
    int n = tt < MA ? 0 : 1 + (tt - MA) / SD;
    logic [NS-1:0] v;
    for (int k = 0; k < NS; k++) v[k] = (k >= n) ? POL : ~POL;
    return v;
  endfunction

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      t = 0; since = 0; prev = 1'b0; m_ack = 1'b0;
    end else begin
      since = since < 3 ? since + 1 : 3;
      if (since > 2) begin
        m_ack = req && !prev;
        if (req) t = 0;
        else if (!prev) t = t + 1;
        prev = req;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_rst", rst_o, exp_rst(t));
    chk("model_ready", ready, t >= MA + (NS - 1) * SD);
    chk("model_ack", ack, m_ack);
  end

  task automatic edge_(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_timeline();
    edge_(9);  chk("rel_e9", rst_o, 3'b111);
    edge_(1);  chk("rel_e10", rst_o, 3'b110);
    edge_(15); chk("rel_e25", rst_o, 3'b110);
    edge_(1);  chk("rel_e26", rst_o, 3'b100);
    edge_(15); chk("rel_e41_ready", ready, 1'b0);
    edge_(1);  chk("rel_e42", rst_o, 3'b000);
    chk("rel_e42_ready", ready, 1'b1);
  endtask

  initial begin
    edge_(3);
    chk("por_rst", rst_o, 3'b111);
    chk("por_ready", ready, 1'b0);
    chk("por_rst1", rst1, 1'b0);
    @(negedge clk) arst = 1'b0;
    edge_(2);
    chk("s1_e2_rst", rst1, 1'b0);
    chk("s1_e2_ready", ready1, 1'b0);
    edge_(1);
    chk("s1_e3_rst", rst1, 1'b1);
    chk("s1_e3_ready", ready1, 1'b1);
    edge_(6);  chk("s1_e9", rst_o, 3'b111);
    edge_(1);  chk("s1_e10", rst_o, 3'b110);
    edge_(15); chk("s1_e25", rst_o, 3'b110);
    edge_(1);  chk("s1_e26", rst_o, 3'b100);
    edge_(15); chk("s1_e41_ready", ready, 1'b0);
    edge_(1);  chk("s1_e42", rst_o, 3'b000);
    chk("s1_e42_ready", ready, 1'b1);
    // single-cycle software request from RUN
    @(negedge clk) req = 1'b1;
    edge_(1);
    chk("sw_rst", rst_o, 3'b111);
    chk("sw_ready", ready, 1'b0);
    chk("sw_ack", ack, 1'b1);
    @(negedge clk) req = 1'b0;
    edge_(1);  chk("sw_ack_gone", ack, 1'b0);
    edge_(7);  chk("sw_e8", rst_o, 3'b111);
    edge_(1);  chk("sw_e9", rst_o, 3'b110);
    edge_(31); chk("sw_e40_ready", ready, 1'b0);
    edge_(1);  chk("sw_e41_ready", ready, 1'b1);
    // held request
    @(negedge clk) req = 1'b1;
    repeat (20) @(negedge clk);
    req = 1'b0;
    edge_(8);  chk("hold_l7", rst_o, 3'b111);
    edge_(1);  chk("hold_l8", rst_o, 3'b110);
    edge_(16); chk("hold_l24", rst_o, 3'b100);
    edge_(2);
    // request after two stages released
    @(negedge clk) req = 1'b1;
    edge_(1);
    chk("mid_rst", rst_o, 3'b111);
    chk("mid_ready", ready, 1'b0);
    @(negedge clk) req = 1'b0;
    edge_(15);
    chk("mid_restart", rst_o, 3'b110);
    // async pulse off the edge with a concurrent request
    #2 arst = 1'b1; req = 1'b1;
    #1;
    chk("apulse_rst", rst_o, 3'b111);
    chk("apulse_ready", ready, 1'b0);
    chk("apulse_ack", ack, 1'b0);
    edge_(2);
    chk("apulse_ack_hold", ack, 1'b0);
    @(negedge clk) begin arst = 1'b0; req = 1'b0; end
    release_timeline();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req = $urandom_range(0, 99) < (i < 1500 ? 2 : 8);
      if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 3)) arst = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        arst = 1'b0;
      end
    end
    @(negedge clk) req = 1'b0;
    repeat (60) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
